// File: rtl/alu_exec_stage.sv
// Execute stage: ADD/NAND ALU with EX/MEM output register and the architectural C/Z flags.
// Define ALU_FLAG_BYPASS_EN to drive carry_fwd/zero_fwd with the flags being produced this cycle.
module alu_exec_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        alu_control,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic [REG_W-1:0]  dest_in,
    input  logic              rf_we_in,
    input  logic              stall,
    input  logic              flush,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] result,
    output logic [REG_W-1:0]  dest_out,
    output logic              rf_we_out,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              carry_fwd,
    output logic              zero_fwd
);

    logic              accept;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W-1:0] nand_res;

    logic              valid_q, valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [REG_W-1:0]  dest_q, dest_d;
    logic              we_q, we_d;
    logic              carry_q, carry_d;
    logic              zero_q, zero_d;

    assign accept   = in_valid && !stall && !flush;
    assign in_ready = !stall;
    assign sum_ext  = {1'b0, op_a} + {1'b0, op_b};

    for (genvar gi = 0; gi < DATA_W; gi++) begin : g_nand
        assign nand_res[gi] = ~(op_a[gi] & op_b[gi]);
    end

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        dest_d   = dest_q;
        we_d     = we_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        // Flush outranks stall: a squashed slot empties even while downstream holds.
        if (flush) begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end else if (stall) begin
            valid_d = valid_q;
        end else if (accept) begin
            valid_d = 1'b1;
            dest_d  = dest_in;
            case (alu_control)
                2'b00: begin
                    result_d = sum_ext[DATA_W-1:0];
                    carry_d  = sum_ext[DATA_W];
                    zero_d   = (sum_ext[DATA_W-1:0] == '0);
                    we_d     = rf_we_in;
                end
                2'b01: begin
                    result_d = nand_res;
                    zero_d   = (nand_res == '0);
                    we_d     = rf_we_in;
                end
                default: begin
                    // Bubble: failed conditional instructions retire here without side effects.
                    result_d = '0;
                    we_d     = 1'b0;
                end
            endcase
        end else begin
            valid_d = 1'b0;
            we_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            dest_q   <= '0;
            we_q     <= 1'b0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            dest_q   <= dest_d;
            we_q     <= we_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign out_valid  = valid_q;
    assign result     = result_q;
    assign dest_out   = dest_q;
    assign rf_we_out  = we_q;
    assign carry_flag = carry_q;
    assign zero_flag  = zero_q;

`ifdef ALU_FLAG_BYPASS_EN
    assign carry_fwd = carry_d;
    assign zero_fwd  = zero_d;
`else
    assign carry_fwd = carry_q;
    assign zero_fwd  = zero_q;
`endif

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage: stimulus pushes expected EX/MEM state, a monitor pops and compares.
module tb_alu_exec_stage;

    logic        clk;
    logic        rst;
    logic [1:0]  alu_control;
    logic        in_valid;
    logic [15:0] op_a, op_b;
    logic [2:0]  dest_in;
    logic        rf_we_in;
    logic        stall, flush;
    logic        in_ready, out_valid;
    logic [15:0] result;
    logic [2:0]  dest_out;
    logic        rf_we_out, carry_flag, zero_flag, carry_fwd, zero_fwd;

    typedef struct {
        logic        v;
        logic [15:0] r;
        logic [2:0]  d;
        logic        we;
        logic        c;
        logic        z;
        logic        chk_res;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    alu_exec_stage #(.DATA_W(16), .REG_W(3)) dut (
        .clk(clk), .rst(rst), .alu_control(alu_control), .in_valid(in_valid),
        .op_a(op_a), .op_b(op_b), .dest_in(dest_in), .rf_we_in(rf_we_in),
        .stall(stall), .flush(flush), .in_ready(in_ready), .out_valid(out_valid),
        .result(result), .dest_out(dest_out), .rf_we_out(rf_we_out),
        .carry_flag(carry_flag), .zero_flag(zero_flag),
        .carry_fwd(carry_fwd), .zero_fwd(zero_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: one expected entry per clock edge issued by the stimulus.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            txn++;
            $display("txn %0d: valid=%0b result=%h dest=%0d we=%0b C=%0b Z=%0b", txn,
                     out_valid, result, dest_out, rf_we_out, carry_flag, zero_flag);
            chk("out_valid", 32'(out_valid), 32'(e.v));
            chk("rf_we_out", 32'(rf_we_out), 32'(e.we));
            chk("carry_flag", 32'(carry_flag), 32'(e.c));
            chk("zero_flag", 32'(zero_flag), 32'(e.z));
            if (e.chk_res) begin
                chk("result", 32'(result), 32'(e.r));
                chk("dest_out", 32'(dest_out), 32'(e.d));
            end
        end
    end

    task automatic drive(input logic r, input logic v, input logic s, input logic f,
                         input logic [1:0] ctl, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] d, input logic we);
        rst = r; in_valid = v; stall = s; flush = f;
        alu_control = ctl; op_a = a; op_b = b; dest_in = d; rf_we_in = we;
        #1;
    endtask

    task automatic expect_out(input logic ev, input logic [15:0] er, input logic [2:0] ed,
                              input logic ewe, input logic ec, input logic ez, input logic cr);
        exp_t e;
        e.v = ev; e.r = er; e.d = ed; e.we = ewe; e.c = ec; e.z = ez; e.chk_res = cr;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        // Reset for two edges
        drive(1, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 3'd0, 0); expect_out(0, 16'h0000, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 2'b00, 16'h1111, 16'h2222, 3'd1, 1); expect_out(0, 16'h0000, 0, 0, 0, 0, 1);
        // ADD / wrap-around / NAND
        drive(0, 1, 0, 0, 2'b00, 16'h0003, 16'h0004, 3'd5, 1); expect_out(1, 16'h0007, 5, 1, 0, 0, 1);
        drive(0, 1, 0, 0, 2'b00, 16'hFFFF, 16'h0001, 3'd2, 1); expect_out(1, 16'h0000, 2, 1, 1, 1, 1);
        drive(0, 1, 0, 0, 2'b01, 16'hFFFF, 16'hFFFF, 3'd3, 1); expect_out(1, 16'h0000, 3, 1, 1, 1, 1);
        drive(0, 1, 0, 0, 2'b01, 16'h00F0, 16'h0F0F, 3'd1, 0); expect_out(1, 16'hFFFF, 1, 0, 1, 0, 1);
        // NOP code 10 with write intent
        drive(0, 1, 0, 0, 2'b10, 16'h1234, 16'h4321, 3'd4, 1); expect_out(1, 16'h0000, 4, 0, 1, 0, 1);
        // ADD then stall three cycles with a new instruction waiting
        drive(0, 1, 0, 0, 2'b00, 16'h1234, 16'h0001, 3'd6, 1); expect_out(1, 16'h1235, 6, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 2'b00, 16'h0001, 16'h0001, 3'd7, 1);
            chk("in_ready_stall", 32'(in_ready), 32'd0);
            expect_out(1, 16'h1235, 6, 1, 0, 0, 1);
        end
        drive(0, 1, 0, 0, 2'b00, 16'h0001, 16'h0001, 3'd7, 1);
        chk("in_ready", 32'(in_ready), 32'd1);
        expect_out(1, 16'h0002, 7, 1, 0, 0, 1);
        // flush together with stall clears the slot, flags untouched
        drive(0, 1, 1, 1, 2'b00, 16'hFFFF, 16'h0001, 3'd2, 1); expect_out(0, 16'h0000, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 2'b00, 16'hFFFF, 16'h0001, 3'd2, 1); expect_out(0, 16'h0000, 0, 0, 0, 0, 0);
        // NOP code 11
        drive(0, 1, 0, 0, 2'b11, 16'h00FF, 16'h0001, 3'd2, 1); expect_out(1, 16'h0000, 2, 0, 0, 0, 1);
        // Flag forwarding for ADD 0x8000 + 0x8000
        drive(0, 1, 0, 0, 2'b00, 16'h8000, 16'h8000, 3'd1, 1);
`ifdef ALU_FLAG_BYPASS_EN
        chk("carry_fwd_same", 32'(carry_fwd), 32'd1);
        chk("zero_fwd_same", 32'(zero_fwd), 32'd1);
`else
        chk("carry_fwd_same", 32'(carry_fwd), 32'd0);
        chk("zero_fwd_same", 32'(zero_fwd), 32'd0);
`endif
        expect_out(1, 16'h0000, 1, 1, 1, 1, 1);
        // Flush alone squashes the incoming ADD
        drive(0, 1, 0, 1, 2'b00, 16'h0001, 16'h0002, 3'd5, 1);
        chk("carry_fwd_next", 32'(carry_fwd), 32'd1);
        chk("zero_fwd_next", 32'(zero_fwd), 32'd1);
        expect_out(0, 16'h0000, 0, 0, 1, 1, 0);
        // Reset mid-stream, then immediate accept
        drive(0, 1, 0, 0, 2'b00, 16'h0005, 16'h0006, 3'd2, 1); expect_out(1, 16'h000B, 2, 1, 0, 0, 1);
        drive(1, 1, 0, 0, 2'b00, 16'h0007, 16'h0007, 3'd3, 1); expect_out(0, 16'h0000, 0, 0, 0, 0, 1);
        drive(0, 1, 0, 0, 2'b00, 16'h0001, 16'h0001, 3'd3, 1); expect_out(1, 16'h0002, 3, 1, 0, 0, 1);
        drive(0, 0, 0, 0, 2'b00, 16'h0000, 16'h0000, 3'd0, 0); expect_out(0, 16'h0000, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
